mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 112 +++++++++++
 tb/tb_mult_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared multi-cycle booth multiplier.
// Round-robin by default; define MULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mult_arbiter #(
    parameter int N       = 4,
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*N-1:0]   req_a,
    input  logic [NUM_REQ*N-1:0]   req_b,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [2*N-1:0]         rsp_product,
    output logic                   busy,
    output logic                   mult_start,
    output logic [N-1:0]           mult_multiplicand,
    output logic [N-1:0]           mult_multiplier,
    input  logic [2*N-1:0]         mult_product,
    input  logic                   mult_done
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
    state_t state;

    logic [IW-1:0]      win;
    logic [NUM_REQ-1:0] win_oh;
    logic [N-1:0]       sel_a, sel_b;

`ifndef MULT_ARB_FIXED_PRIO_EN
    logic [IW-1:0] ptr;

    // Walk from the farthest slot back toward ptr so the nearest requester wins last.
    always_comb begin
        logic [SW-1:0] s;
        s   = '0;
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            s = {1'b0, ptr} + SW'(k);
            if (s >= SW'(NUM_REQ)) s = s - SW'(NUM_REQ);
            if (req[s[IW-1:0]]) win = s[IW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (state == IDLE && |req) begin
            ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) win = IW'(k);
        end
    end
`endif

    assign win_oh = NUM_REQ'(1) << win;
    assign sel_a  = req_a[win*N +: N];
    assign sel_b  = req_b[win*N +: N];

    // Operands stay registered until the next grant, which covers the
    // multiplier's late operand sample one cycle after start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            gnt               <= '0;
            rsp_valid         <= '0;
            rsp_product       <= '0;
            busy              <= 1'b0;
            mult_start        <= 1'b0;
            mult_multiplicand <= '0;
            mult_multiplier   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt               <= win_oh;
                        mult_multiplicand <= sel_a;
                        mult_multiplier   <= sel_b;
                        mult_start        <= 1'b1;
                        busy              <= 1'b1;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    mult_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (mult_done) begin
                        rsp_product <= mult_product;
                        rsp_valid   <= gnt;
                        state       <= RESPOND;
                    end
                end
                RESPOND: begin
                    rsp_valid <= '0;
                    gnt       <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural booth-multiplier stand-in
// and a reference arbitration/product model.
module tb_mult_arbiter;
    localparam int N   = 4;
    localparam int NR  = 4;
    localparam int LAT = 4 * N + 3;

    logic            clock = 1'b0;
    logic            reset_n = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*N-1:0] req_a = '0, req_b = '0;
    logic [NR-1:0]   gnt, rsp_valid;
    logic [2*N-1:0]  rsp_product, mult_product;
    logic            busy, mult_start, mult_done;
    logic [N-1:0]    mult_multiplicand, mult_multiplier;
    logic            extra_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;
    logic [NR-1:0] gnt_seen;

    mult_arbiter #(.N(N), .NUM_REQ(NR)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .busy(busy),
        .mult_start(mult_start), .mult_multiplicand(mult_multiplicand),
        .mult_multiplier(mult_multiplier), .mult_product(mult_product),
        .mult_done(mult_done)
    );

    always #5 clock = ~clock;

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
        int x;
        x = int'($signed(a)) * int'($signed(b));
        return x[2*N-1:0];
    endfunction

    // Multiplier stand-in: samples operands one cycle after start, done LAT cycles after start.
    int            mcnt;
    logic          mdone;
    logic [2*N-1:0] mprod;
    logic [N-1:0]  ma, mb;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcnt <= 0; mdone <= 1'b0; mprod <= '0; ma <= '0; mb <= '0;
        end else begin
            mdone <= 1'b0;
            if (mult_start) mcnt <= LAT;
            else if (mcnt != 0) begin
                if (mcnt == LAT) begin ma <= mult_multiplicand; mb <= mult_multiplier; end
                if (mcnt == 1) begin mdone <= 1'b1; mprod <= prod(ma, mb); end
                mcnt <= mcnt - 1;
            end
        end
    end
    assign mult_done    = mdone | extra_done;
    assign mult_product = mprod;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] pend);
`ifdef MULT_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NR; k++) if (pend[k]) return k;
`else
        for (int k = 0; k < NR; k++) if (pend[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
`endif
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    task automatic run_txn(input logic [NR-1:0] pend, input bit drop, output int w);
        int cyc, lat, starts;
        logic [NR-1:0]  oh;
        logic [N-1:0]   ea, eb;
        logic [2*N-1:0] ep;
        w  = pick(pend);
        oh = NR'(1) << w;
        ea = req_a[w*N +: N];
        eb = req_b[w*N +: N];
        ep = prod(ea, eb);
        cyc = 0;
        while (gnt == '0 && cyc < 50) begin
            @(posedge clock); #1; cyc++;
        end
        gnt_seen |= gnt;
        chk("gnt", gnt, oh);
        chk("start_at_grant", mult_start, 1);
        chk("busy_at_grant", busy, 1);
        chk("op_a_at_grant", mult_multiplicand, ea);
        chk("op_b_at_grant", mult_multiplier, eb);
`ifndef MULT_ARB_FIXED_PRIO_EN
        m_ptr = (w + 1) % NR;
`endif
        lat = 0; starts = 0;
        while (rsp_valid == '0 && lat < 60) begin
            @(posedge clock); #1; lat++;
            gnt_seen |= gnt;
            if (mult_start) starts++;
        end
        chk("latency", lat, 4 * N + 5);
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_product", rsp_product, ep);
        chk("extra_starts", starts, 0);
        chk("op_a_held", mult_multiplicand, ea);
        chk("op_b_held", mult_multiplier, eb);
        if (drop) req[w] = 1'b0;
        @(posedge clock); #1;
        chk("rsp_valid_pulse", rsp_valid, 0);
        chk("gnt_cleared", gnt, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        int w;
        int rv_hits;
        logic [NR-1:0] pend;

        #2 reset_n = 1'b0;
        @(posedge clock); #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_product", rsp_product, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", mult_start, 0);
        chk("rst_op_a", mult_multiplicand, 0);
        chk("rst_op_b", mult_multiplier, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Simultaneous req0/req2 from a fresh pointer
        set_op(0, 4'h8, 4'h8);
        set_op(2, 4'h7, 4'hF);
        req = 4'b0101;
        run_txn(4'b0101, 1, w);
        chk("sim_first", w, 0);
        chk("sim_first_prod", rsp_product, 8'h40);
        run_txn(4'b0100, 1, w);
        chk("sim_second", w, 2);
        chk("sim_second_prod", rsp_product, 8'hF9);

        // Single request 3 * -2
        set_op(0, 4'd3, 4'hE);
        req = 4'b0001;
        run_txn(4'b0001, 1, w);
        chk("single_prod", rsp_product, 8'hFA);

        // Stray done outside WAIT must be ignored
        extra_done = 1'b1;
        @(posedge clock); #1;
        extra_done = 1'b0;
        rv_hits = 0;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid != '0 || busy) rv_hits++;
            @(posedge clock); #1;
        end
        chk("stray_done_ignored", rv_hits, 0);
        chk("stray_done_product", rsp_product, 8'hFA);

        // Fresh pointer for the rotation test
        reset_n = 1'b0; m_ptr = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        gnt_seen = '0;
`ifdef MULT_ARB_FIXED_PRIO_EN
        set_op(0, 4'd2, 4'd3);
        set_op(3, 4'd1, 4'd1);
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_txn(4'b1001, 0, w);
            chk("fixed_winner", w, 0);
        end
        req = '0;
        chk("fixed_starve", gnt_seen[3], 0);
`else
        for (int i = 0; i < NR; i++) set_op(i, N'(i + 1), N'(i + 2));
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 0, w);
            chk("rr_order", w, i % NR);
        end
        req = '0;
        chk("rr_all_granted", gnt_seen, 4'b1111);
`endif
        @(posedge clock); #1;

        // Randomized rounds against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) set_op(i, N'($urandom), N'($urandom));
            pend = NR'($urandom_range(1, (1 << NR) - 1));
            req  = pend;
            while (pend != '0) begin
                run_txn(pend, 1, w);
                pend[w] = 1'b0;
            end
        end

        // Reset during WAIT aborts the operation
        set_op(1, 4'd2, 4'd3);
        req = 4'b0010;
        for (int i = 0; i < 10 && gnt == '0; i++) begin @(posedge clock); #1; end
        repeat (5) begin @(posedge clock); #1; end
        reset_n = 1'b0; m_ptr = 0;
        req = '0;
        #1;
        chk("abort_gnt", gnt, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_product", rsp_product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_start", mult_start, 0);
        chk("abort_op_a", mult_multiplicand, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        rv_hits = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock); #1;
            if (rsp_valid != '0 || gnt != '0) rv_hits++;
        end
        chk("abort_no_rsp", rv_hits, 0);
        set_op(1, 4'd5, 4'd5);
        req = 4'b0010;
        run_txn(4'b0010, 1, w);
        chk("post_reset_winner", w, 1);
        chk("post_reset_prod", rsp_product, 8'h19);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
